// File: rtl/rr_arbiter_nbit.sv
// Round-robin arbiter for 2**N requesters with registered one-hot grant, owner index,
// busy flag and an optional hold limit that preempts a long-running owner.
module rr_arbiter_nbit #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2**N-1:0]   req,
    output logic [2**N-1:0]   gnt,
    output logic [N-1:0]      gnt_idx,
    output logic              busy,
    output logic              timeout
);

    localparam int unsigned NReq  = 2**N;
    localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HoldW-1:0] HoldLast = (MAX_HOLD > 0) ? HoldW'(MAX_HOLD - 1) : '0;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      ptr_q, ptr_d;
    logic [N-1:0]      own_q, own_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [NReq-1:0]   gnt_q, gnt_d;
    logic [N-1:0]      gnt_idx_q, gnt_idx_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              win_found;
    logic [N-1:0]      win_idx;
    logic              owner_req;
    logic              others_req;
    logic              preempt;

    // Circular search starting at ptr_q; the first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int unsigned i = 0; i < NReq; i++) begin
            logic [N-1:0] cand;
            cand = ptr_q + N'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_req  = req[own_q];
        others_req = |(req & ~(NReq'(1) << own_q));
        preempt    = (MAX_HOLD != 0) && owner_req && (hold_q == HoldLast) && others_req;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        own_d     = own_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    own_d     = win_idx;
                    gnt_d     = NReq'(1) << win_idx;
                    gnt_idx_d = win_idx;
                    busy_d    = 1'b1;
                    hold_d    = '0;
                    state_d   = StGrant;
                end
            end
            StGrant: begin
                if (!owner_req || preempt) begin
                    // A release wins over a simultaneous preemption, so timeout only
                    // fires while the owner still wants the resource.
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = own_q + N'(1);
                    timeout_d = owner_req;
                    state_d   = StIdle;
                end else if ((MAX_HOLD != 0) && (hold_q != HoldLast)) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            own_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt));
    a_gnt_matches_idx : assert property (@(posedge clk) disable iff (!reset_n)
        busy |-> (gnt == (NReq'(1) << gnt_idx)));

endmodule

// File: tb/tb_rr_arbiter_nbit.sv
// Directed bench for rr_arbiter_nbit: stimulus pushes expected outputs per cycle into a
// scoreboard queue, a monitor pops and compares each cycle after the clock edge.
module tb_rr_arbiter_nbit;

    logic        clk;
    logic        reset_n;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] g;
        logic [3:0]  ix;
        logic        b;
        logic        t;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    rr_arbiter_nbit #(
        .N        (4),
        .MAX_HOLD (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle that has a pending expectation is compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk({e.tag, ".gnt"},     32'(gnt),     32'(e.g));
                chk({e.tag, ".gnt_idx"}, 32'(gnt_idx), 32'(e.ix));
                chk({e.tag, ".busy"},    32'(busy),    32'(e.b));
                chk({e.tag, ".timeout"}, 32'(timeout), 32'(e.t));
            end
        end
    end

    task automatic step(input logic [15:0] r, input logic [15:0] g, input logic [3:0] ix,
                        input logic b, input logic t, input string tag);
        exp_t e;
        @(negedge clk);
        req = r;
        e.g = g; e.ix = ix; e.b = b; e.t = t; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic step_n(input int n, input logic [15:0] r, input logic [15:0] g,
                          input logic [3:0] ix, input logic b, input logic t, input string tag);
        for (int i = 0; i < n; i++) step(r, g, ix, b, t, tag);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        drain();
        @(negedge clk);
        req     = '0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".gnt"},     32'(gnt),     32'h0);
        chk({tag, ".gnt_idx"}, 32'(gnt_idx), 32'h0);
        chk({tag, ".busy"},    32'(busy),    32'h0);
        chk({tag, ".timeout"}, 32'(timeout), 32'h0);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req     = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset_n = 1'b1;

        // Single requester, then ptr = 6 shown by the next search order.
        step_n(3, 16'h0020, 16'h0020, 4'd5, 1'b1, 1'b0, "single");
        step(16'h0000, 16'h0000, 4'd5, 1'b0, 1'b0, "single_rel");
        step(16'h0041, 16'h0040, 4'd6, 1'b1, 1'b0, "ptr6");
        step(16'h0001, 16'h0000, 4'd6, 1'b0, 1'b0, "ptr6_rel");
        step(16'h0001, 16'h0001, 4'd0, 1'b1, 1'b0, "ptr7_wrap");
        step(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "ptr7_rel");

        // Asynchronous reset in the middle of a grant.
        step(16'h0010, 16'h0010, 4'd4, 1'b1, 1'b0, "pre_rst");
        drain();
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        req     = '0;
        reset_n = 1'b1;
        step(16'h0001, 16'h0001, 4'd0, 1'b1, 1'b0, "post_rst");
        step(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "post_rst_rel");

        // Rotation between requesters 3 and 9.
        do_reset();
        step_n(3, 16'h0208, 16'h0008, 4'd3, 1'b1, 1'b0, "rot_a");
        step(16'h0200, 16'h0000, 4'd3, 1'b0, 1'b0, "rot_gap1");
        step_n(3, 16'h0208, 16'h0200, 4'd9, 1'b1, 1'b0, "rot_b");
        step(16'h0008, 16'h0000, 4'd9, 1'b0, 1'b0, "rot_gap2");
        step_n(3, 16'h0208, 16'h0008, 4'd3, 1'b1, 1'b0, "rot_c");
        step(16'h0200, 16'h0000, 4'd3, 1'b0, 1'b0, "rot_gap3");

        // Wrap: owner 14 releases so ptr = 15.
        step(16'h4000, 16'h4000, 4'd14, 1'b1, 1'b0, "wrap_14");
        step(16'h0000, 16'h0000, 4'd14, 1'b0, 1'b0, "wrap_14_rel");
        step_n(2, 16'h8001, 16'h8000, 4'd15, 1'b1, 1'b0, "wrap_15");
        step(16'h0001, 16'h0000, 4'd15, 1'b0, 1'b0, "wrap_15_rel");
        step(16'h0001, 16'h0001, 4'd0, 1'b1, 1'b0, "wrap_0");
        step(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "wrap_0_rel");

        // Preemption after 16 cycles with two persistent requesters.
        do_reset();
        step_n(16, 16'h0003, 16'h0001, 4'd0, 1'b1, 1'b0, "pre_own0");
        step(16'h0003, 16'h0000, 4'd0, 1'b0, 1'b1, "pre_to0");
        step_n(16, 16'h0003, 16'h0002, 4'd1, 1'b1, 1'b0, "pre_own1");
        step(16'h0003, 16'h0000, 4'd1, 1'b0, 1'b1, "pre_to1");
        step(16'h0003, 16'h0001, 4'd0, 1'b1, 1'b0, "pre_again");
        step(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "pre_rel");

        // Lone owner held indefinitely, preempted as soon as requester 7 appears.
        step_n(40, 16'h0004, 16'h0004, 4'd2, 1'b1, 1'b0, "lone");
        step(16'h0084, 16'h0000, 4'd2, 1'b0, 1'b1, "lone_to");
        step(16'h0084, 16'h0080, 4'd7, 1'b1, 1'b0, "lone_next");
        step(16'h0000, 16'h0000, 4'd7, 1'b0, 1'b0, "lone_next_rel");

        // Release coinciding with the preemption edge counts as a release.
        step_n(16, 16'h0003, 16'h0001, 4'd0, 1'b1, 1'b0, "sim_own0");
        step(16'h0002, 16'h0000, 4'd0, 1'b0, 1'b0, "sim_rel");
        step(16'h0002, 16'h0002, 4'd1, 1'b1, 1'b0, "sim_next");
        step(16'h0000, 16'h0000, 4'd1, 1'b0, 1'b0, "sim_next_rel");

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_nbit.md
# rr_arbiter_nbit

Round-robin arbiter that shares one resource among 2**N requesters. It produces a registered one-hot grant vector and its binary index, and the one-hot vector is generated by shifting a single bit left by the index. Ownership lasts until the owner drops its request. An optional hold limit preempts an owner that keeps the resource while others wait. The block sits between requesting units and a shared bus or unit, and the grant vector drives that resource's select lines directly.

## Interface
- N, default 4: index width; number of requesters is 2**N.
- MAX_HOLD, default 16: maximum consecutive grant cycles while others wait; 0 disables preemption.

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req  input  2**N  request per requester; held high for the whole ownership
- gnt  output  2**N  one-hot grant (all zero when idle), registered
- gnt_idx  output  N  binary index of current/last owner, registered
- busy  output  1  high while any grant is active, registered
- timeout  output  1  one-cycle pulse when an owner is preempted, registered

## Operation
- States: IDLE, GRANT. Internal state also includes:
  - rotating priority pointer ptr, N bits
  - owner index own, N bits
  - hold counter hold_cnt, width $clog2(MAX_HOLD+1)
- Reset (asynchronous, while reset_n low):
  - state = IDLE, ptr = 0, hold_cnt = 0
  - gnt = 0, gnt_idx = 0, busy = 0, timeout = 0
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick the first set req bit found by a circular search starting at ptr: ptr, ptr+1, …, wrapping at 2**N-1 to 0.
  - own = winner; gnt = 1 << winner; gnt_idx = winner; busy = 1; hold_cnt = 0; go to GRANT.
- GRANT, owner release (req[own] low):
  - gnt = 0, busy = 0, ptr = own+1 mod 2**N, go to IDLE.
  - gnt_idx keeps its value.
- GRANT, preemption (MAX_HOLD != 0, req[own] high, hold_cnt == MAX_HOLD-1, and some other req bit set):
  - Same updates as a release, plus timeout = 1 for exactly one cycle.
- GRANT, otherwise:
  - Grant held; hold_cnt increments, saturating at MAX_HOLD-1.
  - If MAX_HOLD == 0, hold_cnt stays 0.
- Outputs are assigned only in the clocked process; there is no combinational path from req to gnt.
- gnt has at most one bit set at all times. gnt[i] high implies gnt_idx == i.
- Requests from other requesters during GRANT do not change gnt; they are only evaluated in IDLE.
- The pointer advances only past the owner that just finished, which guarantees every persistent requester wins within 2**N grants.

## Timing
- Grant latency: req high sampled at edge k in IDLE → gnt set after edge k (same edge the FSM enters GRANT).
- Release latency: req[own] low sampled at edge k → gnt = 0 after edge k.
- Handoff gap: exactly one cycle with gnt == 0 between consecutive owners. The next grant appears after edge k+1.
- Preemption: an owner that keeps req high while others wait holds gnt for exactly MAX_HOLD cycles. The timeout pulse coincides with the first gnt == 0 cycle.
- Lone owner: if no other request is pending, the grant is held indefinitely. hold_cnt stays saturated. The owner is preempted at the first edge where another request is seen.
- Simultaneous events:
  - Owner release and the preemption condition at the same edge count as a release: timeout = 0.
  - Multiple new requests in IDLE: the circular search from ptr decides.
- Wrap-around: own = 2**N-1 sets ptr = 0.
- Reset mid-grant: gnt drops to 0 immediately (asynchronous). After reset_n rises, arbitration restarts from ptr = 0.

## Test plan
- Reset: assert reset_n = 0 during a grant → gnt = 0, gnt_idx = 0, busy = 0, timeout = 0 immediately. After release with req = 0x0001, gnt = 0x0001 one edge later.
- Single requester (N = 4): req = 0x0020 → gnt = 0x0020, gnt_idx = 5 after the first edge. Drop req → gnt = 0 after the next edge; ptr = 6.
- Rotation: from reset, req = 0x0208 held, each owner releasing after 3 cycles then re-requesting → gnt sequence 0x0008, 0x0200, 0x0008, each separated by one gnt = 0 cycle.
- Wrap: ptr = 15 after owner 14 releases, req = 0x8001 → gnt = 0x8000 first. After its release, gnt = 0x0001.
- Preemption (MAX_HOLD = 16): req = 0x0003 held constant → gnt = 0x0001 for 16 cycles, then one cycle with gnt = 0 and timeout = 1, then gnt = 0x0002 for 16 cycles; repeats.
- No preemption: req = 0x0004 alone for 40 cycles → gnt = 0x0004 throughout, timeout never pulses. Raise req[7] → preemption on the next edge.
